// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO stage: register offsets,
// STATUS bit positions and the MMIO window match value.
package data_mem_pkg;

  localparam logic [15:0] OFF_TX_DATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS  = 16'h0004;
  localparam logic [15:0] OFF_CYCLE   = 16'h0008;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVERFLOW = 2;

  localparam logic [15:0] MMIO_MATCH = 16'hFFFF;

  function automatic logic [31:0] status_word(input logic overflow, input logic full,
                                               input logic empty);
    logic [31:0] w;
    w                = 32'h0000_0000;
    w[STAT_OVERFLOW] = overflow;
    w[STAT_FULL]     = full;
    w[STAT_EMPTY]    = empty;
    return w;
  endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// CPU data-port bus plus the transmit valid/ready stream of data_mem_mmio.
interface data_mem_mmio_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output mem_read, mem_write, data_address, data_in, tx_ready,
    input  data_out, tx_data, tx_valid
  );

  modport slave (
    input  mem_read, mem_write, data_address, data_in, tx_ready,
    output data_out, tx_data, tx_valid
  );
endinterface

// File: rtl/data_mem_mmio_tx_fifo.sv
// Synchronous FIFO with simultaneous push/pop allowed while full; head is
// forced to zero when empty so the stream never exposes stale data.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty_o   = (count_q == (PW+1)'(0));
  assign full_o    = (count_q == (PW+1)'(DEPTH));
  assign do_pop_s  = pop_i && !empty_o;
  // A pop on the same edge frees the slot a full-FIFO push needs.
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign head_o    = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {(PW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s && !rst) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data RAM plus MMIO window (TX FIFO, STATUS, CYCLE) behind the CPU data port.
// Define DATA_MEM_CYCLE_CNT_EN to build the free-running CYCLE counter.
module data_mem_mmio
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = {MMIO_MATCH, 16'h0000}
) (
  input logic           clk,
  input logic           rst,
  data_mem_mmio_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram_q [DEPTH_WORDS];
  logic          is_mmio_s;
  logic [15:0]   offset_s;
  logic [AW-1:0] ram_idx_s;
  logic          push_req_s, pop_s, clr_ovf_s;
  logic          full_s, empty_s;
  logic [31:0]   head_s;
  logic [31:0]   cycle_val_s;
  logic [31:0]   rd_val_s;
  logic          overflow_q, overflow_d;

  assign is_mmio_s  = (bus.data_address[31:16] == MMIO_BASE[31:16]);
  assign offset_s   = bus.data_address[15:0];
  assign ram_idx_s  = bus.data_address[AW+1:2];
  assign push_req_s = bus.mem_write && is_mmio_s && (offset_s == OFF_TX_DATA);
  assign clr_ovf_s  = bus.mem_write && is_mmio_s && (offset_s == OFF_STATUS) && bus.data_in[2];
  assign pop_s      = bus.tx_ready && !empty_s;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req_s),
    .pop_i   (pop_s),
    .data_i  (bus.data_in),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign bus.tx_data  = head_s;
  assign bus.tx_valid = !empty_s;

  always_ff @(posedge clk) begin
    if (bus.mem_write && !is_mmio_s) begin
      ram_q[ram_idx_s] <= bus.data_in;
    end
  end

  // A push into a full FIFO is only lost when no pop makes room on that edge.
  always_comb begin
    if (push_req_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else if (clr_ovf_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

`ifdef DATA_MEM_CYCLE_CNT_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= 32'h0000_0000;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign cycle_val_s = cycle_q;
`else
  assign cycle_val_s = 32'h0000_0000;
`endif

  // Loads see pre-edge state, which gives read-before-write for free.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    if (is_mmio_s) begin
      case (offset_s)
        OFF_TX_DATA: rd_val_s = 32'h0000_0000;
        OFF_STATUS:  rd_val_s = status_word(overflow_q, full_s, empty_s);
        OFF_CYCLE:   rd_val_s = cycle_val_s;
        default:     rd_val_s = 32'h0000_0000;
      endcase
    end else begin
      rd_val_s = ram_q[ram_idx_s];
    end
  end

  assign bus.data_out = bus.mem_read ? rd_val_s : 32'h0000_0000;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: directed plan items plus random traffic
// checked against a queue/array reference model.
module tb_data_mem_mmio;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_mmio_if bus();

  data_mem_mmio #(
    .DEPTH_WORDS (256),
    .FIFO_DEPTH  (4),
    .MMIO_BASE   (32'hFFFF_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mram [256];
  logic [31:0] mfifo [$];
  bit          movf;
  logic [31:0] mcyc;

  logic [31:0] rd_exp_q [$];
  string       rd_name_q [$];
  logic [31:0] popped [$];

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:16] == 16'hFFFF) begin
      case (a[15:0])
        16'h0004: return {29'd0, movf, (mfifo.size() == 4), (mfifo.size() == 0)};
`ifdef DATA_MEM_CYCLE_CNT_EN
        16'h0008: return mcyc;
`endif
        default:  return 32'h0;
      endcase
    end
    return mram[(a >> 2) % 256];
  endfunction

  task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input bit rdy, input bit r, input bit use_exp, input logic [31:0] exp_v,
                      input string nm);
    int  pre;
    bit  pop, is_m;
    bus.mem_read     = rd;
    bus.mem_write    = wr;
    bus.data_address = a;
    bus.data_in      = d;
    bus.tx_ready     = rdy;
    rst              = r;
    if (rd) begin
      rd_exp_q.push_back(use_exp ? exp_v : model_read(a));
      rd_name_q.push_back(nm);
    end
    @(posedge clk);
    is_m = (a[31:16] == 16'hFFFF);
    if (r) begin
      mfifo.delete();
      movf = 1'b0;
      mcyc = 32'h0;
    end else begin
      pre = mfifo.size();
      pop = (pre != 0) && rdy;
      if (pop) void'(mfifo.pop_front());
      if (wr && is_m && a[15:0] == 16'h0000) begin
        if (pre < 4 || pop) mfifo.push_back(d);
        else movf = 1'b1;
      end
      if (wr && is_m && a[15:0] == 16'h0004 && d[2]) movf = 1'b0;
      if (wr && !is_m) mram[(a >> 2) % 256] = d;
      mcyc = mcyc + 32'd1;
    end
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0, 32'h0, "");
  endtask

  task automatic rd_const(input logic [31:0] a, input logic [31:0] v, input bit rdy, input string nm);
    step(1'b1, 1'b0, a, 32'h0, rdy, 1'b0, 1'b1, v, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit rdy);
    step(1'b0, 1'b1, a, d, rdy, 1'b0, 1'b0, 32'h0, "");
  endtask

  task automatic check_popped(input logic [31:0] exp_list [$], input string nm);
    checks++;
    if (popped.size() != exp_list.size()) begin
      failures++;
      $display("FAIL %s: popped count %0d, required %0d", nm, popped.size(), exp_list.size());
    end else begin
      for (int i = 0; i < exp_list.size(); i++) begin
        if (popped[i] !== exp_list[i]) begin
          failures++;
          $display("FAIL %s[%0d]: got %h, required %h", nm, i, popped[i], exp_list[i]);
        end
      end
    end
  endtask

  // Scoreboard monitor: read responses and stream beats, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_read) begin
      checks++;
      if (rd_exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got %h, no expectation queued", bus.data_out);
      end else begin
        logic [31:0] e;
        string       n;
        e = rd_exp_q.pop_front();
        n = rd_name_q.pop_front();
        if (bus.data_out !== e) begin
          failures++;
          $display("FAIL read %s addr=%h: got %h, required %h", n, bus.data_address, bus.data_out, e);
        end
      end
    end else begin
      checks++;
      if (bus.data_out !== 32'h0) begin
        failures++;
        $display("FAIL rd_idle_zero: got %h, required 00000000", bus.data_out);
      end
    end
    checks++;
    if (bus.tx_valid !== (mfifo.size() != 0)) begin
      failures++;
      $display("FAIL tx_valid: got %b, required %b", bus.tx_valid, (mfifo.size() != 0));
    end
    checks++;
    if (bus.tx_data !== ((mfifo.size() != 0) ? mfifo[0] : 32'h0)) begin
      failures++;
      $display("FAIL tx_data: got %h, required %h", bus.tx_data,
               (mfifo.size() != 0) ? mfifo[0] : 32'h0);
    end
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) popped.push_back(bus.tx_data);
  end

  initial begin
    logic [31:0] a, d;
    int          sel;
    bit          r_rd, r_wr, r_rdy, r_rst;
    movf = 1'b0;
    mcyc = 32'h0;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, "");
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, "");

    // cycle counter: 10 edges after reset release
    idle(10, 1'b0);
`ifdef DATA_MEM_CYCLE_CNT_EN
    rd_const(32'hFFFF_0008, 32'd10, 1'b0, "cycle_10");
`else
    rd_const(32'hFFFF_0008, 32'd0, 1'b0, "cycle_disabled");
`endif
    rd_const(32'hFFFF_0004, 32'h1, 1'b0, "reset_status");
    rd_const(32'hFFFF_0000, 32'h0, 1'b0, "txdata_reads_zero");
    rd_const(32'hFFFF_000C, 32'h0, 1'b0, "unmapped_zero");

    for (int i = 0; i < 256; i++) wr(i * 4, $urandom, 1'b0);

    wr(32'h40, 32'hDEADBEEF, 1'b0);
    rd_const(32'h40, 32'hDEADBEEF, 1'b0, "ram_0x40");
    rd_const(32'h43, 32'hDEADBEEF, 1'b0, "ram_0x43");
    step(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "");
    wr(32'h400, 32'h1234, 1'b0);
    rd_const(32'h0, 32'h1234, 1'b0, "alias_0x400");
    step(1'b1, 1'b1, 32'h0, 32'hAAAA_5555, 1'b0, 1'b0, 1'b1, 32'h1234, "rbw");
    rd_const(32'h0, 32'hAAAA_5555, 1'b0, "after_rbw");

    // fill and overflow
    for (int i = 1; i <= 5; i++) wr(32'hFFFF_0000, i, 1'b0);
    rd_const(32'hFFFF_0004, 32'h6, 1'b0, "status_full_ovf");
    popped.delete();
    idle(6, 1'b1);
    check_popped('{32'd1, 32'd2, 32'd3, 32'd4}, "drain_order");
    rd_const(32'hFFFF_0004, 32'h5, 1'b1, "status_empty_ovf");
    wr(32'hFFFF_0004, 32'h4, 1'b0);
    rd_const(32'hFFFF_0004, 32'h1, 1'b0, "status_ovf_cleared");

    // simultaneous push/pop while full
    for (int i = 1; i <= 4; i++) wr(32'hFFFF_0000, i, 1'b0);
    wr(32'hFFFF_0000, 32'd9, 1'b1);
    popped.delete();
    rd_const(32'hFFFF_0004, 32'h2, 1'b0, "status_full_no_ovf");
    idle(6, 1'b1);
    check_popped('{32'd2, 32'd3, 32'd4, 32'd9}, "pushpop_drain");

    // mid-operation reset, with and without a push on the reset edge
    wr(32'hFFFF_0000, 32'd7, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, "");
    rd_const(32'hFFFF_0004, 32'h1, 1'b0, "status_after_rst");
    step(1'b0, 1'b1, 32'hFFFF_0000, 32'd8, 1'b1, 1'b1, 1'b0, 32'h0, "");
    rd_const(32'hFFFF_0004, 32'h1, 1'b0, "push_on_rst_dropped");

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      sel   = $urandom_range(0, 9);
      a     = (sel < 5) ? $urandom : {16'hFFFF, 12'h000, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (sel >= 5 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d     = $urandom;
      r_rd  = $urandom_range(0, 1);
      r_wr  = $urandom_range(0, 2) == 0;
      r_rdy = $urandom_range(0, 2) == 0;
      r_rst = $urandom_range(0, 99) == 0;
      if (r_rst) r_wr = 1'b0;
      step(r_rd, r_wr, a, d, r_rdy, r_rst, 1'b0, 32'h0, "random");
    end
    idle(2, 1'b0);

    checks++;
    if (rd_exp_q.size() != 0) begin
      failures++;
      $display("FAIL rd_leftover: %0d expectations pending, required 0", rd_exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-memory stage sitting directly downstream of the single-cycle CPU's data port. It consumes `mem_read`, `mem_write`, `data_address` and `data_in`, and returns `data_out`. It holds a word-addressed data RAM plus a small memory-mapped I/O window containing a transmit FIFO with a valid/ready output handshake, a status register and a free-running cycle counter. Reads are combinational so the CPU keeps its single-cycle timing; all state updates on the rising edge of `clk`.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit RAM words; power of two.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, ≥2.
- `MMIO_BASE`, 32'hFFFF_0000: base of the MMIO window; the decode matches `data_address[31:16]`.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `mem_read`  in  1  read strobe from the CPU.
- `mem_write`  in  1  write strobe from the CPU.
- `data_address`  in  32  byte address from the CPU ALU result.
- `data_in`  in  32  store data from the CPU.
- `data_out`  out  32  load data to the CPU writeback mux; combinational.
- `tx_data`  out  32  FIFO head word.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts the head this cycle.

## Operation
- **Decode:**
  - MMIO when `data_address[31:16] == MMIO_BASE[31:16]`; otherwise RAM.
  - RAM word index = `data_address[log2(DEPTH_WORDS)+1:2]`. Bits [1:0] are ignored. Higher bits alias (modulo wrap).
- **MMIO registers** (offset = `data_address[15:0]`):
  - 0x0 TX_DATA: a write pushes `data_in`. A read returns 0.
  - 0x4 STATUS: a read returns {29'b0, overflow, full, empty}. A write with `data_in[2]=1` clears `overflow`; other bits are ignored.
  - 0x8 CYCLE: a read returns the counter value.
  - Any other offset reads 0; writes to it are ignored.
- **Reads:**
  - `data_out` = selected value while `mem_read=1`, else 32'h0.
  - When `mem_read` and `mem_write` are both set, the read returns the pre-write value (read-before-write).
- **RAM writes:** on the edge when `mem_write=1`. RAM is not cleared by `rst`.
- **FIFO:**
  - Push on a TX_DATA write when not full.
  - Push while full is dropped and sets sticky `overflow`.
  - Pop when `tx_valid && tx_ready`.
  - Push and pop on the same edge while full: both occur, count unchanged, `overflow` not set.
  - Push while empty: no bypass; `tx_valid` rises on the following cycle.
  - `tx_data` = head entry when non-empty, else 32'h0.
  - Pointers wrap modulo `FIFO_DEPTH`. Count width is log2(FIFO_DEPTH)+1.
- **Cycle counter:** 32-bit, +1 every edge, wraps 32'hFFFF_FFFF→0.

## Timing
- **Reset values:**
  - FIFO count and pointers = 0, `overflow` = 0, cycle counter = 0.
  - `tx_valid` = 0, `tx_data` = 0.
  - `data_out` follows the combinational rule above.
- **Mid-operation reset:** `rst` asserted with a pending push or pop discards it; the FIFO is empty after the edge.
- **Latency:**
  - Load: 0 cycles (combinational).
  - Store: visible to a read in the cycle after the edge.
  - TX_DATA push to `tx_valid`: 1 edge.
  - STATUS reflects a push or pop after that edge.
- **Handshake:**
  - `tx_data` stays stable while `tx_valid=1 && tx_ready=0`.
  - `tx_ready` while `tx_valid=0` has no effect.
- **Cycle counter read:** returns the registered value, i.e. the number of edges since reset was released.

## Configuration
- `DATA_MEM_CYCLE_CNT_EN` defined: the CYCLE register and counter are built as above.
- Not defined: no counter flops are built, and reads of offset 0x8 return 32'h0.
- All other behaviour is identical in both builds.

## Structure
- Shared package `data_mem_pkg` holds:
  - the MMIO offsets (TX_DATA, STATUS, CYCLE);
  - the STATUS bit positions (empty=0, full=1, overflow=2);
  - the MMIO decode-match constant.
- One sub-module, `tx_fifo`: parameterised by depth and width, with ports push/pop/full/empty/head. Overflow detection stays in `data_mem_mmio`.

## Test plan
- **RAM store/load:** write 32'hDEADBEEF to 0x40, then read 0x40 and 0x43 → both return 32'hDEADBEEF. Read with `mem_read=0` → 0.
- **Aliasing:** with DEPTH_WORDS=256, write 32'h1234 to 0x400, then read 0x0 → 32'h1234.
- **FIFO fill and overflow:** with `tx_ready=0`, push 1,2,3,4,5.
  - STATUS = 3'b110 (full, overflow set).
  - Raise `tx_ready` → `tx_data` sequence 1,2,3,4, then `tx_valid`=0 and STATUS = 3'b101.
  - Write 32'h4 to STATUS → reads 3'b001.
- **Simultaneous push/pop:** with the FIFO full (1..4) and `tx_ready=1`, push 9 → count stays 4, no overflow; drain order is 2,3,4,9.
- **Mid-operation reset:** push 7, assert `rst` for one edge with `tx_ready=0` → `tx_valid`=0, STATUS=3'b001.
- **Cycle counter:** release reset, wait 10 edges, read 0xFFFF0008 → 10 with `DATA_MEM_CYCLE_CNT_EN` defined, 0 without.
